// File: rtl/fastchip_seq.sv
// fastchip_seq: CPU-to-fastchip bus sequencer.
// Splits word/longword accesses into 16-bit fastchip cycles.
module fastchip_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic        cpu_long,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_legacy,
  output logic        cpu_err,
  output logic        busy,
  output logic        fc_sel,
  output logic        fc_rnw,
  output logic        fc_uds,
  output logic        fc_lds,
  output logic        fc_longword,
  output logic [23:0] fc_addr,
  output logic [15:0] fc_din,
  input  logic        fc_sel_ack,
  input  logic        fc_ready,
  input  logic [15:0] fc_dout
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT,
    GAP,
    DONE
  } state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic [9:0]  wait_cnt;
  logic        second;
  logic        gap_ph;
  logic [15:0] din_lo;

  assign busy = (state != IDLE);

  // Sequencer FSM with registered bus and CPU-side outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      second      <= 1'b0;
      gap_ph      <= 1'b0;
      din_lo      <= '0;
      cpu_dout    <= '0;
      cpu_ack     <= 1'b0;
      cpu_legacy  <= 1'b0;
      cpu_err     <= 1'b0;
      fc_sel      <= 1'b0;
      fc_rnw      <= 1'b0;
      fc_uds      <= 1'b0;
      fc_lds      <= 1'b0;
      fc_longword <= 1'b0;
      fc_addr     <= '0;
      fc_din      <= '0;
    end else begin
      cpu_ack    <= 1'b0;
      cpu_legacy <= 1'b0;
      cpu_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            second      <= 1'b0;
            gap_ph      <= 1'b0;
            din_lo      <= cpu_din[15:0];
            fc_sel      <= 1'b1;
            fc_addr     <= {cpu_addr, 1'b0};
            fc_rnw      <= cpu_rnw;
            fc_uds      <= cpu_uds;
            fc_lds      <= cpu_lds;
            fc_longword <= cpu_long;
            fc_din      <= cpu_long ? cpu_din[31:16]
                                    : cpu_din[15:0];
            wait_cnt    <= '0;
            state       <= CHECK;
          end
        end
        CHECK, WAIT: begin
          if (state == CHECK && !fc_sel_ack) begin
            fc_sel      <= 1'b0;
            fc_longword <= 1'b0;
            cpu_legacy  <= 1'b1;
            state       <= IDLE;
          end else if (fc_ready) begin
            if (fc_longword && !second) begin
              if (fc_rnw) cpu_dout[31:16] <= fc_dout;
              state <= GAP;
            end else begin
              if (fc_rnw) begin
                cpu_dout[15:0] <= fc_dout;
                if (!fc_longword) cpu_dout[31:16] <= fc_dout;
              end
              state <= DONE;
            end
          end else if (wait_cnt == TO_LAST) begin
            wait_cnt    <= wait_cnt + 10'd1;
            fc_sel      <= 1'b0;
            fc_longword <= 1'b0;
            cpu_dout    <= '1;
            cpu_err     <= 1'b1;
            cpu_ack     <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
            state    <= WAIT;
          end
        end
        GAP: begin
          if (!gap_ph) begin
            gap_ph  <= 1'b1;
            fc_sel  <= 1'b0;
            fc_addr <= fc_addr + 24'd2;
            fc_din  <= din_lo;
          end else begin
            gap_ph   <= 1'b0;
            fc_sel   <= 1'b1;
            second   <= 1'b1;
            wait_cnt <= '0;
            state    <= CHECK;
          end
        end
        DONE: begin
          fc_sel      <= 1'b0;
          fc_longword <= 1'b0;
          cpu_ack     <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fastchip_seq.sv
// tb_fastchip_seq: directed checks for fastchip_seq.
// Uses TIMEOUT=4 so the abort path is reachable quickly.
module tb_fastchip_seq;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [22:0] cpu_addr;
  logic        cpu_rnw;
  logic        cpu_uds;
  logic        cpu_lds;
  logic        cpu_long;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        cpu_legacy;
  logic        cpu_err;
  logic        busy;
  logic        fc_sel;
  logic        fc_rnw;
  logic        fc_uds;
  logic        fc_lds;
  logic        fc_longword;
  logic [23:0] fc_addr;
  logic [15:0] fc_din;
  logic        fc_sel_ack;
  logic        fc_ready;
  logic [15:0] fc_dout;

  int vecs = 0;
  int errs = 0;

  fastchip_seq #(.TIMEOUT(4)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_rnw     (cpu_rnw),
    .cpu_uds     (cpu_uds),
    .cpu_lds     (cpu_lds),
    .cpu_long    (cpu_long),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .cpu_legacy  (cpu_legacy),
    .cpu_err     (cpu_err),
    .busy        (busy),
    .fc_sel      (fc_sel),
    .fc_rnw      (fc_rnw),
    .fc_uds      (fc_uds),
    .fc_lds      (fc_lds),
    .fc_longword (fc_longword),
    .fc_addr     (fc_addr),
    .fc_din      (fc_din),
    .fc_sel_ack  (fc_sel_ack),
    .fc_ready    (fc_ready),
    .fc_dout     (fc_dout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic setup(input logic [22:0] a, input logic rnw,
                       input logic lng, input logic [31:0] d);
    cpu_addr = a;
    cpu_rnw  = rnw;
    cpu_long = lng;
    cpu_din  = d;
    cpu_uds  = 1'b1;
    cpu_lds  = 1'b1;
    cpu_req  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    cpu_rnw = 1'b1;
    cpu_uds = 1'b0;
    cpu_lds = 1'b0;
    cpu_long = 1'b0;
    cpu_din = '0;
    fc_sel_ack = 1'b0;
    fc_ready = 1'b0;
    fc_dout = '0;
    tick();
    tick();
    vecs++;
    if ({fc_sel, fc_longword, fc_addr, fc_din, cpu_dout,
         cpu_ack, cpu_legacy, cpu_err, busy} !== '0) begin
      errs++;
      $display("FAIL reset_state: sel=%b addr=%h dout=%h busy=%b want all 0",
               fc_sel, fc_addr, cpu_dout, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_word_read();
    int n;
    fc_sel_ack = 1'b1;
    fc_ready = 1'b1;
    fc_dout = 16'h1234;
    setup(23'h5C0008, 1'b1, 1'b0, 32'h0);
    tick();
    cpu_req = 1'b0;
    vecs++;
    if (fc_sel !== 1'b1 || fc_addr !== 24'hB80010 || busy !== 1'b1) begin
      errs++;
      $display("FAIL word_read_issue: sel=%b addr=%h busy=%b want 1 b80010 1",
               fc_sel, fc_addr, busy);
    end
    n = 1;
    while (cpu_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vecs++;
    if (n != 3) begin
      errs++;
      $display("FAIL word_read_latency: got %0d cycles want 3", n);
    end
    vecs++;
    if (cpu_dout !== 32'h12341234 || cpu_err !== 1'b0) begin
      errs++;
      $display("FAIL word_read_data: got %h err=%b want 12341234 0",
               cpu_dout, cpu_err);
    end
    fc_ready = 1'b0;
    tick();
    vecs++;
    if (cpu_ack !== 1'b0 || fc_sel !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL word_read_end: ack=%b sel=%b busy=%b want 0 0 0",
               cpu_ack, fc_sel, busy);
    end
  endtask

  task automatic test_long_write();
    fc_sel_ack = 1'b1;
    fc_ready = 1'b0;
    setup(23'h6D0000, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    cpu_req = 1'b0;
    vecs++;
    if (fc_sel !== 1'b1 || fc_addr !== 24'hDA0000 || fc_din !== 16'hDEAD ||
        fc_longword !== 1'b1 || fc_rnw !== 1'b0) begin
      errs++;
      $display("FAIL long_wr_hi: sel=%b addr=%h din=%h lw=%b rnw=%b",
               fc_sel, fc_addr, fc_din, fc_longword, fc_rnw);
    end
    tick();
    tick();
    fc_ready = 1'b1;
    tick();
    fc_ready = 1'b0;
    vecs++;
    if (fc_sel !== 1'b1 || fc_longword !== 1'b1 || cpu_ack !== 1'b0) begin
      errs++;
      $display("FAIL long_wr_gap_in: sel=%b lw=%b ack=%b want 1 1 0",
               fc_sel, fc_longword, cpu_ack);
    end
    tick();
    vecs++;
    if (fc_sel !== 1'b0 || fc_addr !== 24'hDA0002 || fc_din !== 16'hBEEF ||
        fc_longword !== 1'b1) begin
      errs++;
      $display("FAIL long_wr_gap: sel=%b addr=%h din=%h lw=%b want 0 da0002 beef 1",
               fc_sel, fc_addr, fc_din, fc_longword);
    end
    tick();
    vecs++;
    if (fc_sel !== 1'b1 || fc_longword !== 1'b1 || fc_addr !== 24'hDA0002) begin
      errs++;
      $display("FAIL long_wr_lo: sel=%b lw=%b addr=%h want 1 1 da0002",
               fc_sel, fc_longword, fc_addr);
    end
    tick();
    tick();
    fc_ready = 1'b1;
    tick();
    fc_ready = 1'b0;
    vecs++;
    if (cpu_ack !== 1'b0 || fc_longword !== 1'b1) begin
      errs++;
      $display("FAIL long_wr_early: ack=%b lw=%b want 0 1", cpu_ack, fc_longword);
    end
    tick();
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_dout !== 32'h12341234) begin
      errs++;
      $display("FAIL long_wr_ack: ack=%b err=%b dout=%h want 1 0 12341234",
               cpu_ack, cpu_err, cpu_dout);
    end
    tick();
    vecs++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL long_wr_single_ack: ack=%b busy=%b want 0 0",
               cpu_ack, busy);
    end
  endtask

  task automatic test_legacy();
    fc_sel_ack = 1'b0;
    fc_ready = 1'b1;
    setup(23'h000080, 1'b1, 1'b0, 32'h0);
    tick();
    cpu_req = 1'b0;
    vecs++;
    if (fc_sel !== 1'b1 || fc_addr !== 24'h000100) begin
      errs++;
      $display("FAIL legacy_issue: sel=%b addr=%h want 1 000100",
               fc_sel, fc_addr);
    end
    tick();
    vecs++;
    if (fc_sel !== 1'b0 || cpu_legacy !== 1'b1 || cpu_ack !== 1'b0 ||
        cpu_dout !== 32'h12341234) begin
      errs++;
      $display("FAIL legacy_pulse: sel=%b leg=%b ack=%b dout=%h",
               fc_sel, cpu_legacy, cpu_ack, cpu_dout);
    end
    tick();
    fc_ready = 1'b0;
    vecs++;
    if (cpu_legacy !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errs++;
      $display("FAIL legacy_end: leg=%b busy=%b ack=%b want 0 0 0",
               cpu_legacy, busy, cpu_ack);
    end
  endtask

  task automatic test_timeout();
    int n;
    fc_sel_ack = 1'b1;
    fc_ready = 1'b0;
    setup(23'h000200, 1'b1, 1'b0, 32'h0);
    tick();
    cpu_req = 1'b0;
    n = 0;
    while (cpu_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 2) fc_sel_ack = 1'b0;
    end
    vecs++;
    if (n != 4) begin
      errs++;
      $display("FAIL timeout_latency: got %0d cycles want 4", n);
    end
    vecs++;
    if (cpu_err !== 1'b1 || cpu_dout !== 32'hFFFFFFFF || fc_sel !== 1'b0) begin
      errs++;
      $display("FAIL timeout_abort: err=%b dout=%h sel=%b want 1 ffffffff 0",
               cpu_err, cpu_dout, fc_sel);
    end
    tick();
    vecs++;
    if (cpu_err !== 1'b0 || cpu_ack !== 1'b0 || fc_sel !== 1'b0) begin
      errs++;
      $display("FAIL timeout_end: err=%b ack=%b sel=%b want 0 0 0",
               cpu_err, cpu_ack, fc_sel);
    end
  endtask

  task automatic test_word_write();
    int n;
    fc_sel_ack = 1'b1;
    fc_ready = 1'b0;
    fc_dout = 16'h7777;
    setup(23'h001000, 1'b0, 1'b0, 32'hCAFE5A5A);
    tick();
    vecs++;
    if (fc_din !== 16'h5A5A || fc_rnw !== 1'b0 || fc_longword !== 1'b0 ||
        fc_addr !== 24'h002000) begin
      errs++;
      $display("FAIL word_wr_issue: din=%h rnw=%b lw=%b addr=%h",
               fc_din, fc_rnw, fc_longword, fc_addr);
    end
    cpu_addr = 23'h000333;
    tick();
    fc_ready = 1'b1;
    n = 0;
    while (cpu_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    fc_ready = 1'b0;
    vecs++;
    if (n != 2 || cpu_dout !== 32'hFFFFFFFF || cpu_err !== 1'b0) begin
      errs++;
      $display("FAIL word_wr_done: n=%0d dout=%h err=%b want 2 ffffffff 0",
               n, cpu_dout, cpu_err);
    end
    tick();
    tick();
    vecs++;
    if (busy !== 1'b0 || fc_sel !== 1'b0) begin
      errs++;
      $display("FAIL req_not_queued: busy=%b sel=%b want 0 0", busy, fc_sel);
    end
  endtask

  task automatic test_long_wrap();
    int n;
    fc_sel_ack = 1'b1;
    fc_ready = 1'b1;
    fc_dout = 16'hAAAA;
    setup(23'h7FFFFF, 1'b1, 1'b1, 32'h0);
    tick();
    cpu_req = 1'b0;
    vecs++;
    if (fc_addr !== 24'hFFFFFE) begin
      errs++;
      $display("FAIL wrap_hi_addr: got %h want fffffe", fc_addr);
    end
    tick();
    tick();
    fc_dout = 16'h5555;
    vecs++;
    if (fc_addr !== 24'h000000 || fc_sel !== 1'b0) begin
      errs++;
      $display("FAIL wrap_lo_addr: addr=%h sel=%b want 000000 0",
               fc_addr, fc_sel);
    end
    n = 3;
    while (cpu_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    fc_ready = 1'b0;
    vecs++;
    if (n != 6 || cpu_dout !== 32'hAAAA5555) begin
      errs++;
      $display("FAIL wrap_long_read: n=%0d dout=%h want 6 aaaa5555",
               n, cpu_dout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    fc_sel_ack = 1'b1;
    fc_ready = 1'b0;
    setup(23'h000400, 1'b1, 1'b0, 32'h0);
    tick();
    cpu_req = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    vecs++;
    if (fc_sel !== 1'b0 || busy !== 1'b0 || cpu_dout !== 32'h0 ||
        fc_addr !== 24'h0) begin
      errs++;
      $display("FAIL async_reset: sel=%b busy=%b dout=%h addr=%h want 0",
               fc_sel, busy, cpu_dout, fc_addr);
    end
    #2;
    reset_n = 1'b1;
    fc_ready = 1'b1;
    fc_dout = 16'h0F0F;
    setup(23'h000010, 1'b1, 1'b0, 32'h0);
    tick();
    cpu_req = 1'b0;
    vecs++;
    if (fc_sel !== 1'b1 || fc_addr !== 24'h000020) begin
      errs++;
      $display("FAIL post_reset_accept: sel=%b addr=%h want 1 000020",
               fc_sel, fc_addr);
    end
    n = 1;
    while (cpu_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    fc_ready = 1'b0;
    vecs++;
    if (n != 3 || cpu_dout !== 32'h0F0F0F0F) begin
      errs++;
      $display("FAIL post_reset_read: n=%0d dout=%h want 3 0f0f0f0f",
               n, cpu_dout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_long_write();
    test_legacy();
    test_timeout();
    test_word_write();
    test_long_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
